// File: rtl/acc_mem_pkg.sv
// Shared widths, FSM state encoding and line-slot mapping for the accelerator memory responder.
package acc_mem_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LINE_W     = 512;
    localparam int unsigned WORDS      = LINE_W / DATA_W;
    localparam int unsigned SRAM_AW    = ADDR_W - 2;
    localparam int unsigned IDX_W      = $clog2(WORDS);
    localparam int unsigned LINE_IDX_W = $clog2(LINE_W);

    typedef enum logic [2:0] {
        IDLE,
        READ_ISSUE,
        READ_DRAIN,
        READ_RESP,
        WRITE_ISSUE,
        WRITE_RESP
    } state_t;

    // Word i of a line sits at the top end: lowest address is most significant.
    function automatic logic [LINE_IDX_W-1:0] slot_msb(input logic [IDX_W-1:0] idx);
        return LINE_IDX_W'(LINE_W - 1 - DATA_W * 32'(idx));
    endfunction

endpackage

// File: rtl/acc_line_assembler.sv
// Slot register that collects burst read words into one line.
module acc_line_assembler
    import acc_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (we_i) begin
            line_q[slot_msb(idx_i) -: DATA_W] <= wdata_i;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/acc_mem_responder.sv
// Accelerator line-read / word-write responder sharing one SRAM port with the CPU (CPU first),
// plus the registered CPU-write snoop.
module acc_mem_responder
    import acc_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_mem_en,
    input  logic               cpu_mem_we,
    input  logic [ADDR_W-1:0]  cpu_mem_addr,
    input  logic [DATA_W-1:0]  cpu_mem_wdata,
    output logic [DATA_W-1:0]  cpu_mem_rdata,
    output logic               mem_listen_en,
    output logic [ADDR_W-1:0]  mem_listen_addr,
    output logic [DATA_W-1:0]  mem_listen_data,
    input  logic               mem_acc_read_en,
    input  logic [ADDR_W-1:0]  mem_acc_read_addr,
    output logic [LINE_W-1:0]  mem_acc_read_data,
    output logic               mem_acc_read_data_valid,
    input  logic               mem_acc_write_en,
    input  logic [ADDR_W-1:0]  mem_acc_write_addr,
    input  logic [DATA_W-1:0]  mem_acc_write_data,
    output logic               mem_acc_write_done,
    output logic               acc_req_err,
    output logic               sram_en,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    input  logic [DATA_W-1:0]  sram_rdata
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [SRAM_AW-1:0]  base_q, base_d;
    logic [SRAM_AW-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                issued_q;
    logic [IDX_W-1:0]    idx_q;
    logic [LINE_W-1:0]   rd_line_q;
    logic                valid_q, done_q, err_q;
    logic                listen_en_q;
    logic [ADDR_W-1:0]   listen_addr_q;
    logic [DATA_W-1:0]   listen_data_q;
    logic                issue_rd_c, issue_wr_c, drop_c;
    logic [LINE_W-1:0]   asm_line;
    logic                unused_bits;

    assign unused_bits = ^{cpu_mem_addr[1:0], mem_acc_read_addr[1:0],
                           mem_acc_write_addr[1:0], asm_line[DATA_W-1:0]};

    // Next-state, SRAM arbitration and request-drop detection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        issue_rd_c = 1'b0;
        issue_wr_c = 1'b0;
        drop_c     = (state_q == IDLE) ? (mem_acc_read_en & mem_acc_write_en)
                                       : (mem_acc_read_en | mem_acc_write_en);
        case (state_q)
            IDLE: begin
                if (mem_acc_read_en) begin
                    base_d  = mem_acc_read_addr[ADDR_W-1:2];
                    cnt_d   = '0;
                    state_d = READ_ISSUE;
                end else if (mem_acc_write_en) begin
                    wr_addr_d = mem_acc_write_addr[ADDR_W-1:2];
                    wr_data_d = mem_acc_write_data;
                    state_d   = WRITE_ISSUE;
                end
            end
            READ_ISSUE: begin
                if (!cpu_mem_en) begin
                    issue_rd_c = 1'b1;
                    cnt_d      = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(WORDS - 1)) begin
                        state_d = READ_DRAIN;
                    end
                end
            end
            READ_DRAIN:  state_d = READ_RESP;
            READ_RESP:   state_d = IDLE;
            WRITE_ISSUE: begin
                if (!cpu_mem_en) begin
                    issue_wr_c = 1'b1;
                    state_d    = WRITE_RESP;
                end
            end
            WRITE_RESP:  state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        sram_en    = cpu_mem_en | issue_rd_c | issue_wr_c;
        sram_we    = cpu_mem_en ? cpu_mem_we : issue_wr_c;
        sram_addr  = cpu_mem_en ? cpu_mem_addr[ADDR_W-1:2]
                   : (issue_wr_c ? wr_addr_q : base_q + SRAM_AW'(cnt_q));
        sram_wdata = cpu_mem_en ? cpu_mem_wdata : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            issued_q  <= 1'b0;
            idx_q     <= '0;
            rd_line_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            issued_q  <= issue_rd_c;
            idx_q     <= cnt_q;
            valid_q   <= (state_d == READ_RESP);
            done_q    <= (state_d == WRITE_RESP);
            err_q     <= drop_c;
            // Last word arrives in the drain cycle; publish the whole line at once.
            if (state_q == READ_DRAIN) begin
                rd_line_q <= {asm_line[LINE_W-1:DATA_W], sram_rdata};
            end
        end
    end

    // CPU write snoop.
    always_ff @(posedge clk) begin
        if (rst) begin
            listen_en_q   <= 1'b0;
            listen_addr_q <= '0;
            listen_data_q <= '0;
        end else begin
            listen_en_q <= cpu_mem_en & cpu_mem_we;
            if (cpu_mem_en & cpu_mem_we) begin
                listen_addr_q <= cpu_mem_addr;
                listen_data_q <= cpu_mem_wdata;
            end
        end
    end

    acc_line_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .we_i    (issued_q),
        .idx_i   (idx_q),
        .wdata_i (sram_rdata),
        .line_o  (asm_line)
    );

    assign cpu_mem_rdata           = sram_rdata;
    assign mem_listen_en           = listen_en_q;
    assign mem_listen_addr         = listen_addr_q;
    assign mem_listen_data         = listen_data_q;
    assign mem_acc_read_data       = rd_line_q;
    assign mem_acc_read_data_valid = valid_q;
    assign mem_acc_write_done      = done_q;
    assign acc_req_err             = err_q;

endmodule

// File: doc/acc_mem_responder.md
Name: acc_mem_responder

Overview:
Data-memory-side responder for the hash accelerator's memory interface. It serves accelerator line reads by fetching 16 consecutive 32-bit words from a single-port 32-bit SRAM and returning one 512-bit line. It serves accelerator 32-bit word writes. It shares the SRAM with the CPU, giving the CPU absolute priority, and produces the registered MMIO snoop (mem_listen_*) that the accelerator control unit monitors.

Parameters:
ADDR_W, 16, byte address width on CPU and accelerator sides
DATA_W, 32, SRAM/CPU word width
LINE_W, 512, accelerator read line width; WORDS = LINE_W/DATA_W = 16
SRAM_AW, 14, SRAM word index width (ADDR_W-2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_mem_en  in  1  CPU access this cycle
cpu_mem_we  in  1  CPU write (qualified by cpu_mem_en)
cpu_mem_addr  in  ADDR_W  CPU byte address
cpu_mem_wdata  in  DATA_W  CPU write data
cpu_mem_rdata  out  DATA_W  CPU read data, 1-cycle latency (sram_rdata pass-through)
mem_listen_en  out  1  registered copy of CPU write strobe
mem_listen_addr  out  ADDR_W  registered CPU write address
mem_listen_data  out  DATA_W  registered CPU write data
mem_acc_read_en  in  1  accelerator line-read request pulse
mem_acc_read_addr  in  ADDR_W  line base byte address
mem_acc_read_data  out  LINE_W  assembled line
mem_acc_read_data_valid  out  1  one-cycle line-valid pulse
mem_acc_write_en  in  1  accelerator word-write request pulse
mem_acc_write_addr  in  ADDR_W  write byte address
mem_acc_write_data  in  DATA_W  write data
mem_acc_write_done  out  1  one-cycle write-complete pulse
acc_req_err  out  1  one-cycle pulse when a request is dropped
sram_en, sram_we  out  1 each  SRAM strobes
sram_addr  out  SRAM_AW  SRAM word index (byte addr[ADDR_W-1:2])
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after read issue

Behaviour:
- Reset: all outputs, the line register, counters and the listen registers are 0; FSM goes to IDLE. Reset mid-burst or mid-write discards the operation. No valid/done pulse follows.
- Addresses: byte addresses. addr[1:0] is ignored. Burst word i is at base+4*i, using 16-bit wrap-around arithmetic.
- SRAM mux: if cpu_mem_en, the CPU drives the SRAM this cycle. Otherwise the FSM may issue. cpu_mem_rdata = sram_rdata always.
- Listen: when cpu_mem_en&cpu_mem_we at cycle T, mem_listen_* carry addr/data during T+1, with en=1. Otherwise en=0 and addr/data hold their last value.
- FSM states: IDLE, READ_ISSUE, READ_DRAIN, READ_RESP, WRITE_ISSUE, WRITE_RESP.
- IDLE + read_en: latch base, cnt=0 -> READ_ISSUE.
- IDLE + write_en (read_en=0): latch addr/data -> WRITE_ISSUE.
- IDLE with read_en and write_en together: read wins, write is dropped, acc_req_err pulses.
- Any request while not IDLE: dropped, acc_req_err pulses the next cycle.
- READ_ISSUE: in each cycle with no CPU access, issue a read of word cnt and increment cnt. After word 15 is issued -> READ_DRAIN.
- Capture rule: a 1-bit issued_q flag with a 4-bit index. When set, sram_rdata goes into slot idx. Word i occupies bits [LINE_W-1-32*i -: 32], so the lowest address is most significant.
- READ_DRAIN: capture the last word -> READ_RESP. READ_RESP: valid=1 for exactly one cycle -> IDLE. mem_acc_read_data holds until the next valid.
- Read latency without CPU contention: read_en at T; issues T+1..T+16; valid high in T+18. Each CPU-stolen cycle adds 1.
- WRITE_ISSUE: issue the SRAM write on the first CPU-free cycle -> WRITE_RESP. WRITE_RESP: done=1 for one cycle -> IDLE.
- Write latency without CPU contention: write_en at T; SRAM write in T+1; done in T+2.
- No coherence tracking: a CPU write and an accelerator access to the same word take effect in SRAM issue order.

Decomposition:
- Package acc_mem_pkg holds the width localparams (ADDR_W, DATA_W, LINE_W, WORDS), the state_t enum, and the word-slot index helper.
- One sub-module, acc_line_assembler: a 16×32 slot register with write-enable/index input and a 512-bit output.
- The FSM, SRAM mux and listen registers live in the top level.

Test Plan:
- Reset, then read_en with base 0x1008 and SRAM word k = 0xA0000000+k -> valid exactly at T+18; line[511:480]=0xA0000402, line[31:0]=0xA0000411; sram_addr 0x402..0x411.
- Same read with cpu_mem_en held for 3 cycles mid-burst -> CPU gets the SRAM in those cycles; valid at T+21; line unchanged.
- write_en with addr 0x5008, data 0xDEADBEEF -> sram_we in T+1 at sram_addr 0x1402; done in T+2; readback via CPU = 0xDEADBEEF.
- CPU write 0x1000<-0x00000001 -> mem_listen_en=1 with that addr/data the next cycle only; a CPU read gives mem_listen_en=0.
- read_en and write_en in the same cycle, then write_en during a burst -> read completes normally; acc_req_err pulses twice; no SRAM write occurs.
- rst asserted at burst cycle 8 -> valid never pulses, outputs are 0, and a fresh read afterwards completes at T+18.
